// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO timer/console responder: register indices,
// STATUS bit positions and reset values.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_CMP    = 2'd1,
    REG_STATUS = 2'd2,
    REG_TX     = 2'd3
  } reg_idx_e;

  localparam int STATUS_FLAG_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_W   = 4;

  localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with concurrent push/pop; a push into a full FIFO is
// accepted when a pop frees a slot on the same edge, otherwise it is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;

  // Head is forced to zero while empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_timer_console.sv
// MMIO responder on the core data port: free-running cycle counter, compare
// timer with sticky interrupt flag, and a byte FIFO streamed to a console.
module mmio_timer_console
  import mmio_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sel,
  input  logic                    wEn,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [31:0]             d_write_data,
  output logic [31:0]             d_read_data,
  output logic                    timer_irq,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] cycle_count;
  logic [31:0] timer_cmp;
  logic        timer_flag;
  logic        overflow;
  logic        wr;
  reg_idx_e    idx;
  logic        tx_push;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_drop;
  logic [CW-1:0] fifo_count;
  logic [31:0] status_word;
  logic        timer_hit;
  logic        unused_addr;

  assign unused_addr = ^{d_address[ADDRESS_BITS-1:4], d_address[1:0]};

  assign idx       = reg_idx_e'(d_address[3:2]);
  assign wr        = sel & wEn;
  assign tx_push   = wr & (idx == REG_TX);
  assign timer_hit = (cycle_count == timer_cmp);

  // Console stream: a byte transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready, and
  // out_data is meaningful only while out_valid is high.
  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clock),
    .rst_n    (reset),
    .push     (tx_push),
    .push_data(d_write_data[7:0]),
    .pop      (out_ready),
    .pop_data (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .drop     (fifo_drop)
  );

  assign out_valid = ~fifo_empty;
  assign timer_irq = timer_flag;

  always_comb begin
    status_word = '0;
    status_word[STATUS_FLAG_BIT] = timer_flag;
    status_word[STATUS_FULL_BIT] = fifo_full;
    status_word[STATUS_OVF_BIT]  = overflow;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(fifo_count);
  end

  always_comb begin
    d_read_data = '0;
    if (sel) begin
      case (idx)
        REG_CYCLE:  d_read_data = cycle_count;
        REG_CMP:    d_read_data = timer_cmp;
        REG_STATUS: d_read_data = status_word;
        default:    d_read_data = '0;
      endcase
    end
  end

  // Setting events take priority over a same-edge write-1-to-clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      timer_cmp   <= TIMER_CMP_RESET;
      timer_flag  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (wr && idx == REG_CMP) timer_cmp <= d_write_data;
      if (timer_hit)
        timer_flag <= 1'b1;
      else if (wr && idx == REG_STATUS && d_write_data[STATUS_FLAG_BIT])
        timer_flag <= 1'b0;
      if (fifo_drop)
        overflow <= 1'b1;
      else if (wr && idx == REG_STATUS && d_write_data[STATUS_OVF_BIT])
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer_console.sv
// Directed bench for mmio_timer_console: inputs change on the falling edge,
// outputs are sampled shortly after, the DUT acts on the rising edge.
module tb_mmio_timer_console;

  logic        clock;
  logic        reset;
  logic        sel;
  logic        wEn;
  logic [15:0] d_address;
  logic [31:0] d_write_data;
  logic [31:0] d_read_data;
  logic        timer_irq;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mmio_timer_console #(
    .ADDRESS_BITS(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sel         (sel),
    .wEn         (wEn),
    .d_address   (d_address),
    .d_write_data(d_write_data),
    .d_read_data (d_read_data),
    .timer_irq   (timer_irq),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic write_reg(input logic [1:0] idx, input logic [31:0] data);
    sel = 1'b1; wEn = 1'b1;
    d_address = {12'h000, idx, 2'b00};
    d_write_data = data;
    @(negedge clock);
    sel = 1'b0; wEn = 1'b0; d_write_data = '0;
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [31:0] data);
    sel = 1'b1; wEn = 1'b0;
    d_address = {12'h000, idx, 2'b00};
    #1 data = d_read_data;
    sel = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (exp_q.size() < 8) exp_q.push_back(b);
    write_reg(2'd3, {24'h0, b});
  endtask

  logic [31:0] rd;
  logic [7:0]  exp_b;

  initial begin
    reset = 1'b0; sel = 1'b0; wEn = 1'b0; d_address = '0;
    d_write_data = '0; out_ready = 1'b0;
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_out_data", {24'h0, out_data}, 32'h0);
    check("reset_irq", {31'h0, timer_irq}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // counter after 10 rising edges
    repeat (10) @(negedge clock);
    read_reg(2'd0, rd); check("cycle_at_10", rd, 32'd10);
    read_reg(2'd2, rd); check("status_idle", rd, 32'h0);
    read_reg(2'd1, rd); check("cmp_reset", rd, 32'hFFFF_FFFF);
    check("idle_out_valid", {31'h0, out_valid}, 32'h0);

    // timer match at 20: counter 10 -> 11 on the write edge
    write_reg(2'd1, 32'd20);
    repeat (9) @(negedge clock);
    read_reg(2'd0, rd); check("cycle_at_match", rd, 32'd20);
    check("irq_before_match", {31'h0, timer_irq}, 32'h0);
    @(negedge clock);
    check("irq_after_match", {31'h0, timer_irq}, 32'h1);

    // W1C clear; a same-cycle read still sees the flag
    sel = 1'b1; wEn = 1'b1; d_address = 16'h0008; d_write_data = 32'h1;
    #1 check("status_read_during_w1c", d_read_data, 32'h1);
    @(negedge clock);
    sel = 1'b0; wEn = 1'b0;
    check("irq_cleared", {31'h0, timer_irq}, 32'h0);

    // clear on the exact match edge: set wins (counter 22 -> 23 on write)
    write_reg(2'd1, 32'd30);
    repeat (7) @(negedge clock);
    read_reg(2'd0, rd); check("cycle_at_match2", rd, 32'd30);
    check("irq_before_match2", {31'h0, timer_irq}, 32'h0);
    write_reg(2'd2, 32'h1);
    check("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    write_reg(2'd2, 32'h1);
    check("irq_cleared2", {31'h0, timer_irq}, 32'h0);

    // fill the FIFO with the consumer stalled
    push_byte(8'h41);
    check("push_latency_valid", {31'h0, out_valid}, 32'h1);
    check("push_latency_data", {24'h0, out_data}, 32'h41);
    for (int i = 1; i < 8; i++) push_byte(8'(8'h41 + i));
    read_reg(2'd2, rd); check("status_full", rd, 32'h82);
    push_byte(8'h49);
    read_reg(2'd2, rd); check("status_overflow", rd, 32'h86);

    // full + push + pop on the same edge
    out_ready = 1'b1;
    #1 check("head_before_concurrent", {24'h0, out_data}, {24'h0, exp_q[0]});
    exp_b = exp_q.pop_front();
    exp_q.push_back(8'h50);
    write_reg(2'd3, 32'h50);
    read_reg(2'd2, rd); check("status_full_concurrent", rd, 32'h86);

    // drain, one byte per cycle
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      #1;
      exp_b = exp_q.pop_front();
      check("drain_valid", {31'h0, out_valid}, 32'h1);
      check("drain_data", {24'h0, out_data}, {24'h0, exp_b});
      @(negedge clock);
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    #1 check("drained_out_valid", {31'h0, out_valid}, 32'h0);
    out_ready = 1'b0;
    read_reg(2'd2, rd); check("status_drained", rd, 32'h04);
    write_reg(2'd2, 32'h4);
    read_reg(2'd2, rd); check("status_ovf_cleared", rd, 32'h0);

    // deselected write and read
    sel = 1'b0; wEn = 1'b1; d_address = 16'h000C; d_write_data = 32'h77;
    #1 check("unselected_read", d_read_data, 32'h0);
    @(negedge clock);
    wEn = 1'b0;
    check("unselected_no_push", {31'h0, out_valid}, 32'h0);
    read_reg(2'd2, rd); check("unselected_status", rd, 32'h0);

    // reset mid-stream with 3 bytes queued
    for (int i = 0; i < 3; i++) write_reg(2'd3, 32'(8'hA0 + i));
    read_reg(2'd2, rd); check("status_three", rd, 32'h30);
    #2 reset = 1'b0;
    #1 check("reset_async_valid", {31'h0, out_valid}, 32'h0);
    check("reset_async_data", {24'h0, out_data}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    read_reg(2'd2, rd); check("status_after_reset", rd, 32'h0);
    read_reg(2'd0, rd); check("cycle_after_reset", rd, 32'h0);
    @(negedge clock);
    read_reg(2'd0, rd); check("cycle_restart", rd, 32'h1);
    read_reg(2'd1, rd); check("cmp_after_reset", rd, 32'hFFFF_FFFF);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_timer_console.md
# mmio_timer_console

Memory-mapped I/O responder for the single-cycle core's data port. It answers the same combinational-read / clocked-write accesses that main memory answers, decoded by a top-level select. It provides three functions:
- a free-running cycle counter;
- a compare timer with an interrupt flag;
- an 8-deep byte FIFO, drained by an external consumer over a valid/ready stream (console/debug output).

## Interface
Parameters:
- ADDRESS_BITS, 16, width of d_address (matches core data port)
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- sel  in  1  block selected (top-level address decode)
- wEn  in  1  data-port write enable
- d_address  in  ADDRESS_BITS  byte address; only [3:2] decoded
- d_write_data  in  32  write data
- d_read_data  out  32  combinational read data
- timer_irq  out  1  equals timer_flag
- out_valid  out  1  FIFO non-empty
- out_data  out  8  FIFO head byte
- out_ready  in  1  consumer accepts head

## Operation
Register map (d_address[3:2]):
- 0 CYCLE: read returns 32-bit counter; writes ignored
- 1 TIMER_CMP: read/write, 32 bits
- 2 STATUS: read {24'b0, count[3:0], 1'b0, overflow, full, timer_flag}
  - write is write-1-to-clear: bit0 clears timer_flag, bit2 clears overflow
- 3 TX_DATA: write pushes d_write_data[7:0]; read returns 0

Counter:
- increments every cycle; wraps 0xFFFFFFFF → 0

Timer:
- when the pre-increment counter equals TIMER_CMP, timer_flag is set next edge
- same-cycle set and W1C clear: set wins

Selection:
- sel=0: d_read_data = 0; writes ignored
- write takes effect only when sel & wEn at the edge

FIFO:
- push and pop are concurrent
- push accepted if count < FIFO_DEPTH, or if a pop occurs the same cycle (full + push + pop leaves count unchanged)
- rejected push: data dropped, overflow sticky set
- pop when out_valid & out_ready
- out_data is valid only while out_valid; pointers wrap modulo FIFO_DEPTH
- count is FIFO_DEPTH+1 values wide (4 bits at default); full = (count == FIFO_DEPTH)

## Timing
- Reset values:
  - counter 0, TIMER_CMP 0xFFFFFFFF, timer_flag 0, overflow 0
  - FIFO empty: out_valid 0, out_data 0
  - timer_irq 0
- Reads are zero-latency combinational and reflect state before the current edge; a write and a read to the same register in one cycle return the old value.
- Push-to-out_valid latency is 1 cycle, with no bypass when empty.
- The pop updates the head on the same edge; the next entry is visible the following cycle.
- Reset asserted mid-stream empties the FIFO instantly; the consumer must ignore the aborted transfer.
- Consumer may hold out_ready high continuously (1 byte/cycle throughput).

## Structure
- Shared package `mmio_pkg`:
  - register index constants (REG_CYCLE=0, REG_CMP=1, REG_STATUS=2, REG_TX=3)
  - STATUS bit positions
  - TIMER_CMP reset value
- Sub-module `sync_fifo` (WIDTH, DEPTH params; push/pop/full/empty/count), instantiated once for TX.
- Register decode, counter and timer live in the top of this block.

## Test plan
- Reset release, no accesses, read CYCLE at cycle 10 → returns 10; STATUS reads 0; out_valid 0.
- Write TIMER_CMP=20 → timer_irq rises on the edge after the counter equals 20. Then:
  - write STATUS=0x1 → irq clears next cycle;
  - clear on the exact match cycle → irq stays 1.
- out_ready=0, write TX_DATA 0x41..0x48 (8 pushes) → STATUS = 0x82 (count 8, full).
  - 9th write 0x49 → STATUS = 0x86 (overflow set); 0x49 lost.
- From full, out_ready=1 and push 0x50 in the same cycle → count stays 8.
  - Drained order is 0x41..0x48 then 0x50, one byte per cycle.
- sel=0 with wEn=1 to TX_DATA → no push; d_read_data=0.
- Reset driven low while FIFO holds 3 bytes → out_valid 0 immediately; after release, STATUS=0 and counter restarts at 0.
